// File: rtl/moving_average2_threshold_detect.sv
// rtl/moving_average2_threshold_detect.sv - hysteresis/debounce level detector on the moving-average output
// Includes warm-up suppression, rise/fall pulses and a saturating rise count.
module moving_average2_threshold_detect #(
    parameter logic signed [7:0] HI_THRESH = 8'sd40,
    parameter logic signed [7:0] LO_THRESH = -8'sd40,
    parameter int                DEBOUNCE  = 3,
    parameter int                WARMUP    = 16
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic signed [7:0] sample_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic [7:0]        count_o,
    output logic              warm_o
);

    localparam logic [1:0] ST_WARM = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam int             DW          = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0]  DEB_LAST    = DW'(DEBOUNCE - 1);
    localparam logic [7:0]     WARM_LAST   = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
    localparam logic [1:0]     RESET_STATE = (WARMUP == 0) ? ST_LOW : ST_WARM;
    localparam logic           RESET_WARM  = (WARMUP == 0);

    logic [1:0]    state;
    logic [DW-1:0] deb;
    logic [7:0]    warm_cnt;

    logic hi_q;
    logic lo_q;
    logic deb_hit;
    logic rise_now;
    logic fall_now;

    assign hi_q     = (sample_i >= HI_THRESH);
    assign lo_q     = (sample_i <= LO_THRESH);
    assign deb_hit  = (deb == DEB_LAST);
    assign rise_now = valid_i && (state == ST_LOW)  && hi_q && deb_hit;
    assign fall_now = valid_i && (state == ST_HIGH) && lo_q && deb_hit;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state    <= RESET_STATE;
            deb      <= '0;
            warm_cnt <= 8'd0;
            level_o  <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
            count_o  <= 8'd0;
            warm_o   <= RESET_WARM;
        end else begin
            rise_o <= rise_now;
            fall_o <= fall_now;

            // A rise on the same edge as a clear leaves exactly one counted event.
            if (rise_now) begin
                if (clear_i)
                    count_o <= 8'd1;
                else if (count_o != 8'hFF)
                    count_o <= count_o + 8'd1;
            end else if (clear_i) begin
                count_o <= 8'd0;
            end

            if (valid_i) begin
                case (state)
                    ST_WARM: begin
                        if (warm_cnt == WARM_LAST) begin
                            state  <= ST_LOW;
                            warm_o <= 1'b1;
                        end
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                    ST_LOW: begin
                        if (rise_now) begin
                            state   <= ST_HIGH;
                            level_o <= 1'b1;
                            deb     <= '0;
                        end else if (hi_q) begin
                            deb <= deb + DW'(1);
                        end else begin
                            deb <= '0;
                        end
                    end
                    ST_HIGH: begin
                        if (fall_now) begin
                            state   <= ST_LOW;
                            level_o <= 1'b0;
                            deb     <= '0;
                        end else if (lo_q) begin
                            deb <= deb + DW'(1);
                        end else begin
                            deb <= '0;
                        end
                    end
                    default: begin
                        state <= RESET_STATE;
                        deb   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moving_average2_threshold_detect.sv
// tb/tb_moving_average2_threshold_detect.sv - directed bench for moving_average2_threshold_detect
module tb_moving_average2_threshold_detect;

    logic              clk;
    logic              rstn;
    logic signed [7:0] sample;
    logic              valid;
    logic              clear;
    logic              level;
    logic              rise;
    logic              fall;
    logic [7:0]        count;
    logic              warm;

    int n_checks = 0;
    int n_fail   = 0;

    moving_average2_threshold_detect #(
        .HI_THRESH(8'sd40),
        .LO_THRESH(-8'sd40),
        .DEBOUNCE (3),
        .WARMUP   (16)
    ) dut (
        .system1000     (clk),
        .system1000_rstn(rstn),
        .sample_i       (sample),
        .valid_i        (valid),
        .clear_i        (clear),
        .level_o        (level),
        .rise_o         (rise),
        .fall_o         (fall),
        .count_o        (count),
        .warm_o         (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock edge with the given inputs; outputs are then observed 1ns after the edge
    task automatic step(input logic signed [7:0] s, input logic v, input logic c);
        @(negedge clk);
        sample = s;
        valid  = v;
        clear  = c;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_rise(input logic c);
        step(8'sd100, 1'b1, 1'b0);
        step(8'sd100, 1'b1, 1'b0);
        step(8'sd100, 1'b1, c);
    endtask

    task automatic do_fall();
        for (int i = 0; i < 3; i++) step(-8'sd100, 1'b1, 1'b0);
    endtask

    task automatic warm_up(input string tag);
        for (int i = 0; i < 15; i++) begin
            step(8'sd100, 1'b1, 1'b0);
            check({tag, "_warm_pending"}, warm, 0);
            check({tag, "_no_rise"}, rise, 0);
        end
        step(8'sd100, 1'b1, 1'b0);
        check({tag, "_warm_done"}, warm, 1);
        check({tag, "_level_low"}, level, 0);
        check({tag, "_no_rise_16"}, rise, 0);
    endtask

    int exp_cnt;
    int seen_rise;
    int seen_fall;
    int seq_a[6];

    initial begin
        rstn   = 1'b0;
        sample = '0;
        valid  = 1'b0;
        clear  = 1'b0;
        #12;
        check("rst_level", level, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_count", count, 0);
        check("rst_warm", warm, 0);
        @(negedge clk);
        rstn = 1'b1;

        warm_up("w1");
        step(8'sd100, 1'b1, 1'b0);
        check("r1_rise_1", rise, 0);
        step(8'sd100, 1'b1, 1'b0);
        check("r1_rise_2", rise, 0);
        step(8'sd100, 1'b1, 1'b0);
        check("r1_rise_3", rise, 1);
        check("r1_level", level, 1);
        check("r1_count", count, 1);
        step(8'sd0, 1'b0, 1'b0);
        check("r1_pulse_end", rise, 0);
        check("r1_level_hold", level, 1);

        // gaps: -40 inclusive, idle cycles hold the debounce count
        step(-8'sd40, 1'b1, 1'b0);
        check("gap_fall_a", fall, 0);
        for (int i = 0; i < 5; i++) begin
            step(8'sd0, 1'b0, 1'b0);
            check("gap_idle_fall", fall, 0);
        end
        step(-8'sd41, 1'b1, 1'b0);
        check("gap_fall_b", fall, 0);
        step(-8'sd90, 1'b1, 1'b0);
        check("gap_fall_c", fall, 1);
        check("gap_rise_c", rise, 0);
        check("gap_level", level, 0);
        check("gap_count", count, 1);
        step(8'sd0, 1'b0, 1'b0);
        check("gap_pulse_end", fall, 0);

        // debounce broken by an in-band sample
        seq_a = '{50, 50, 10, 50, 50, 50};
        for (int i = 0; i < 6; i++) begin
            step(8'(seq_a[i]), 1'b1, 1'b0);
            check("deb_rise", rise, (i == 5) ? 1 : 0);
        end
        check("deb_level", level, 1);
        check("deb_count", count, 2);

        // hysteresis in HIGH then in LOW
        seen_fall = 0;
        for (int i = 0; i < 20; i++) begin
            step(-8'sd39, 1'b1, 1'b0);
            seen_fall += int'(fall);
        end
        check("hys_hi_fall", seen_fall, 0);
        check("hys_hi_level", level, 1);
        do_fall();
        check("hys_fall", fall, 1);
        seen_rise = 0;
        for (int i = 0; i < 20; i++) begin
            step(8'sd39, 1'b1, 1'b0);
            seen_rise += int'(rise);
        end
        check("hys_lo_rise", seen_rise, 0);
        check("hys_lo_level", level, 0);

        // clear on the rise edge keeps exactly one event
        do_rise(1'b1);
        check("clr_rise_pulse", rise, 1);
        check("clr_rise_count", count, 1);
        do_fall();
        step(8'sd0, 1'b0, 1'b1);
        check("clr_alone_count", count, 0);
        check("clr_alone_level", level, 0);

        // saturation
        exp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            do_rise(1'b0);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (i >= 250) begin
                check("sat_rise_pulse", rise, 1);
                check("sat_count", count, exp_cnt);
            end
            do_fall();
        end
        check("sat_final", count, 255);

        // async reset mid-debounce
        step(8'sd100, 1'b1, 1'b0);
        step(8'sd100, 1'b1, 1'b0);
        check("ar_pre_rise", rise, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_warm", warm, 0);
        check("ar_level", level, 0);
        check("ar_rise", rise, 0);
        @(negedge clk);
        rstn = 1'b1;
        warm_up("w2");
        do_rise(1'b0);
        check("w2_rise", rise, 1);
        check("w2_count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
